// File: rtl/vsmp_pkg.sv
// rtl/vsmp_pkg.sv - shared VSMP opcodes, ALU function codes and sequencer states
package vsmp_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU function codes; the ALU decodes the same values
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } seq_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/vsmp_program_counter.sv
// rtl/vsmp_program_counter.sv - program counter with increment, load and async reset
module vsmp_program_counter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    output logic [DATA_W-1:0] pc
);

    // Load wins over increment; increment wraps naturally at 2^DATA_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/vsmp_control_sequencer.sv
// rtl/vsmp_control_sequencer.sv - VSMP fetch/decode/execute controller
module vsmp_control_sequencer
    import vsmp_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RUN,
    input  logic [DATA_W+3:0]   INSTR,
    input  logic                ZERO,
    input  logic                CARRY,
    output logic [DATA_W-1:0]   PCOUT,
    output logic [DATA_W-1:0]   DATA,
    output logic [2:0]          ALUOP,
    output logic                LOADA,
    output logic                LOADB,
    output logic                ENABLEALU,
    output logic                ENABLEINSTR,
    output logic                HALTED
);

    seq_state_t          state;
    logic [DATA_W+3:0]   ir;
    logic                z_flag;
    logic                c_flag;
    logic [3:0]          op;
    logic [DATA_W-1:0]   imm;
    logic [3:0]          alu_sel;
    logic                pc_inc;
    logic                jump_taken;

    assign op      = ir[DATA_W+3:DATA_W];
    assign imm     = ir[DATA_W-1:0];
    assign alu_sel = op - OP_ADD;

    assign pc_inc     = (state == ST_FETCH) && RUN;
    // Flags only change at the end of an ALU-op EXECUTE, so the stored values are current here
    assign jump_taken = (state == ST_EXECUTE) &&
                        ((op == OP_JMP) || ((op == OP_JZ) && z_flag) || ((op == OP_JC) && c_flag));

    vsmp_program_counter #(.DATA_W(DATA_W)) u_pc (
        .clk        (CLK),
        .rst        (RST),
        .inc        (pc_inc),
        .load       (jump_taken),
        .load_value (imm),
        .pc         (PCOUT)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_FETCH;
            ir          <= '0;
            z_flag      <= 1'b0;
            c_flag      <= 1'b0;
            DATA        <= '0;
            ALUOP       <= '0;
            LOADA       <= 1'b0;
            LOADB       <= 1'b0;
            ENABLEALU   <= 1'b0;
            ENABLEINSTR <= 1'b0;
            HALTED      <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (RUN) begin
                        ir    <= INSTR;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXECUTE;
                    case (op)
                        OP_LDA: begin
                            LOADA       <= 1'b1;
                            ENABLEINSTR <= 1'b1;
                            DATA        <= imm;
                        end
                        OP_LDB: begin
                            LOADB       <= 1'b1;
                            ENABLEINSTR <= 1'b1;
                            DATA        <= imm;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            LOADA     <= 1'b1;
                            ENABLEALU <= 1'b1;
                            ALUOP     <= alu_sel[2:0];
                        end
                        OP_HLT: begin
                            state  <= ST_HALT;
                            HALTED <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EXECUTE: begin
                    LOADA       <= 1'b0;
                    LOADB       <= 1'b0;
                    ENABLEALU   <= 1'b0;
                    ENABLEINSTR <= 1'b0;
                    if (is_alu_op(op)) begin
                        z_flag <= ZERO;
                        c_flag <= CARRY;
                    end
                    state <= ST_FETCH;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_vsmp_control_sequencer.sv
// tb/tb_vsmp_control_sequencer.sv - directed self-checking bench for vsmp_control_sequencer
module tb_vsmp_control_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN = 1'b0;
    logic [7:0] INSTR;
    logic       ZERO = 1'b0;
    logic       CARRY = 1'b0;
    logic [3:0] PCOUT;
    logic [3:0] DATA;
    logic [2:0] ALUOP;
    logic       LOADA, LOADB, ENABLEALU, ENABLEINSTR, HALTED;

    logic [7:0] prog [16];
    logic [3:0] ctl;
    int total = 0;
    int bad = 0;

    assign INSTR = prog[PCOUT];
    assign ctl   = {LOADA, LOADB, ENABLEALU, ENABLEINSTR};

    always #5 CLK = ~CLK;

    vsmp_control_sequencer #(.DATA_W(4)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .ZERO(ZERO), .CARRY(CARRY),
        .PCOUT(PCOUT), .DATA(DATA), .ALUOP(ALUOP), .LOADA(LOADA), .LOADB(LOADB),
        .ENABLEALU(ENABLEALU), .ENABLEINSTR(ENABLEINSTR), .HALTED(HALTED)
    );

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // Leaves the bench at the negedge inside cycle 1 (first FETCH at address 0)
    task automatic do_reset(input logic run_val);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        RUN = run_val;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RUN = 1'b1;
        step(2);
        total++; if (PCOUT !== 4'd0) begin bad++; $display("FAIL reset_pcout got=%0d exp=0", PCOUT); end
        total++; if (DATA !== 4'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", DATA); end
        total++; if (ALUOP !== 3'd0) begin bad++; $display("FAIL reset_aluop got=%0d exp=0", ALUOP); end
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
        total++; if (HALTED !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", HALTED); end
    endtask

    task automatic test_program();
        clear_prog();
        prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'h30; prog[3] = 8'hF0;
        do_reset(1'b1);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL prog_c1_ctl got=%b exp=0000", ctl); end
        step(2);
        total++; if (ctl !== 4'b1001) begin bad++; $display("FAIL prog_lda_ctl got=%b exp=1001", ctl); end
        total++; if (DATA !== 4'd5) begin bad++; $display("FAIL prog_lda_data got=%0d exp=5", DATA); end
        step(1);
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL prog_c4_ctl got=%b exp=0000", ctl); end
        step(2);
        total++; if (ctl !== 4'b0101) begin bad++; $display("FAIL prog_ldb_ctl got=%b exp=0101", ctl); end
        total++; if (DATA !== 4'd3) begin bad++; $display("FAIL prog_ldb_data got=%0d exp=3", DATA); end
        step(3);
        total++; if (ctl !== 4'b1010) begin bad++; $display("FAIL prog_add_ctl got=%b exp=1010", ctl); end
        total++; if (ALUOP !== 3'd0) begin bad++; $display("FAIL prog_add_aluop got=%0d exp=0", ALUOP); end
        step(3);
        total++; if (HALTED !== 1'b1) begin bad++; $display("FAIL prog_halted got=%b exp=1", HALTED); end
        total++; if (PCOUT !== 4'd4) begin bad++; $display("FAIL prog_halt_pc got=%0d exp=4", PCOUT); end
        step(6);
        total++; if (HALTED !== 1'b1) begin bad++; $display("FAIL prog_halt_hold got=%b exp=1", HALTED); end
        total++; if (PCOUT !== 4'd4) begin bad++; $display("FAIL prog_halt_pc_hold got=%0d exp=4", PCOUT); end
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL prog_halt_ctl got=%b exp=0000", ctl); end
    endtask

    task automatic test_wrap();
        clear_prog();
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) begin
            total++; if (PCOUT !== 4'(i)) begin bad++; $display("FAIL wrap_pc got=%0d exp=%0d", PCOUT, i); end
            for (int k = 0; k < 3; k++) begin
                total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL wrap_ctl got=%b exp=0000 at instr %0d", ctl, i); end
                step(1);
            end
        end
        total++; if (PCOUT !== 4'd0) begin bad++; $display("FAIL wrap_pc_end got=%0d exp=0", PCOUT); end
    endtask

    // Enters at the FETCH of an ALU op; drives flags during its EXECUTE, returns at the next FETCH
    task automatic alu_with_flags(input logic z, input logic c);
        step(2);
        ZERO = z; CARRY = c;
        step(1);
        ZERO = 1'b0; CARRY = 1'b0;
    endtask

    task automatic test_cond_jump();
        clear_prog();
        prog[0] = 8'h40; prog[1] = 8'h99; prog[2] = 8'hA5;
        prog[9] = 8'h40; prog[10] = 8'h93;
        prog[11] = 8'h40; prog[12] = 8'hA0;
        do_reset(1'b1);
        alu_with_flags(1'b1, 1'b0);
        total++; if (ALUOP !== 3'd1) begin bad++; $display("FAIL jz_sub_aluop got=%0d exp=1", ALUOP); end
        step(3);
        total++; if (PCOUT !== 4'd9) begin bad++; $display("FAIL jz_taken got=%0d exp=9", PCOUT); end
        alu_with_flags(1'b0, 1'b0);
        step(3);
        total++; if (PCOUT !== 4'd11) begin bad++; $display("FAIL jz_not_taken got=%0d exp=11", PCOUT); end
        alu_with_flags(1'b0, 1'b1);
        step(3);
        total++; if (PCOUT !== 4'd0) begin bad++; $display("FAIL jc_taken got=%0d exp=0", PCOUT); end
        alu_with_flags(1'b0, 1'b0);
        step(3);
        total++; if (PCOUT !== 4'd2) begin bad++; $display("FAIL jz_cleared got=%0d exp=2", PCOUT); end
        step(3);
        total++; if (PCOUT !== 4'd3) begin bad++; $display("FAIL jc_not_taken got=%0d exp=3", PCOUT); end
    endtask

    task automatic test_run_hold();
        clear_prog();
        prog[0] = 8'h17;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            total++; if (PCOUT !== 4'd0) begin bad++; $display("FAIL hold_pc got=%0d exp=0", PCOUT); end
            total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL hold_ctl got=%b exp=0000", ctl); end
            step(1);
        end
        RUN = 1'b1;
        step(2);
        RUN = 1'b0;
        total++; if (ctl !== 4'b1001) begin bad++; $display("FAIL runlow_lda_ctl got=%b exp=1001", ctl); end
        total++; if (DATA !== 4'd7) begin bad++; $display("FAIL runlow_lda_data got=%0d exp=7", DATA); end
        step(1);
        total++; if (PCOUT !== 4'd1) begin bad++; $display("FAIL runlow_pc got=%0d exp=1", PCOUT); end
        step(3);
        total++; if (PCOUT !== 4'd1) begin bad++; $display("FAIL runlow_pc_hold got=%0d exp=1", PCOUT); end
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL runlow_ctl got=%b exp=0000", ctl); end
    endtask

    task automatic test_reset_mid();
        clear_prog();
        prog[0] = 8'h30;
        do_reset(1'b1);
        step(2);
        total++; if (ctl !== 4'b1010) begin bad++; $display("FAIL mid_add_ctl got=%b exp=1010", ctl); end
        #2 RST = 1'b1;
        #1;
        total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL mid_rst_ctl got=%b exp=0000", ctl); end
        total++; if (PCOUT !== 4'd0) begin bad++; $display("FAIL mid_rst_pc got=%0d exp=0", PCOUT); end
        total++; if (HALTED !== 1'b0) begin bad++; $display("FAIL mid_rst_halted got=%b exp=0", HALTED); end
        @(negedge CLK);
        RST = 1'b0;
        RUN = 1'b1;
        step(1);
        total++; if (PCOUT !== 4'd1) begin bad++; $display("FAIL mid_refetch_pc got=%0d exp=1", PCOUT); end
        step(1);
        total++; if (ctl !== 4'b1010) begin bad++; $display("FAIL mid_refetch_ctl got=%b exp=1010", ctl); end
    endtask

    task automatic test_illegal();
        clear_prog();
        prog[0] = 8'hB0; prog[1] = 8'hC0; prog[2] = 8'hD0; prog[3] = 8'hE0; prog[4] = 8'h8F;
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL illegal_ctl got=%b exp=0000 at cycle %0d", ctl, i); end
            step(1);
        end
        total++; if (PCOUT !== 4'd15) begin bad++; $display("FAIL jmp15_pc got=%0d exp=15", PCOUT); end
        step(1);
        total++; if (PCOUT !== 4'd0) begin bad++; $display("FAIL jmp15_wrap got=%0d exp=0", PCOUT); end
        total++; if (HALTED !== 1'b0) begin bad++; $display("FAIL illegal_halted got=%b exp=0", HALTED); end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_program();
        test_wrap();
        test_cond_jump();
        test_run_hold();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence ended");
        $fatal(1);
    end

endmodule

// File: doc/vsmp_control_sequencer.md
# vsmp_control_sequencer

Fetch/decode/execute controller for the 4-bit VSMP datapath. It owns the program counter, fetches 8-bit instruction words from program memory, and drives the internal-bus controls (LOADA, LOADB, ENABLEALU, ENABLEINSTR), the immediate DATA nibble and the ALU operation select. It also latches ALU flags for conditional jumps. It sits between program memory and the internal bus / ALU pair.

## Interface
- DATA_W, 4, datapath and PC width; instruction word is 4-bit opcode + DATA_W-bit immediate
- CLK  in  1  system clock; all sequencer state changes on posedge
- RST  in  1  asynchronous, active-high reset
- RUN  in  1  1 = sequencer may begin a new fetch; 0 = hold in FETCH
- INSTR  in  4+DATA_W  program word at PCOUT: [7:4] opcode, [3:0] immediate
- ZERO  in  1  ALU result-zero flag
- CARRY  in  1  ALU carry/borrow flag
- PCOUT  out  DATA_W  program memory address
- DATA  out  DATA_W  immediate driven onto the internal bus
- ALUOP  out  3  ALU function select
- LOADA, LOADB, ENABLEALU, ENABLEINSTR  out  1 each  internal-bus controls
- HALTED  out  1  1 after HLT executes, until reset

## Operation
- FSM states: FETCH, DECODE, EXECUTE, HALT.
- FETCH: if RUN=1, register INSTR into IR, PC <= PC+1 (wraps 15->0), go to DECODE; if RUN=0, stay with no side effects.
- DECODE: compute next controls from IR; go to EXECUTE (or HALT for HLT).
- EXECUTE: controls held at their registered values for the whole cycle; go to FETCH.
- Opcodes: 0 NOP; 1 LDA imm (LOADA, ENABLEINSTR, DATA=imm); 2 LDB imm (LOADB, ENABLEINSTR, DATA=imm); 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR (LOADA, ENABLEALU, ALUOP=opcode-3, i.e. 0..4); 8 JMP imm; 9 JZ imm; A JC imm; F HLT; B-E execute as NOP.
- Jumps: at the end of EXECUTE, PC <= imm if JMP, or JZ with Z=1, or JC with C=1; otherwise PC is unchanged (already incremented).
- Flags Z/C are sampled from ZERO/CARRY at the end of an ALU-op EXECUTE only. Other instructions leave them unchanged.
- HALT: HALTED=1, all bus controls 0, PC frozen; exit only via RST. RUN is ignored in HALT.
- Invariants: ENABLEALU and ENABLEINSTR are never both 1. LOADA and LOADB are never both 1. All bus controls are 0 outside EXECUTE.

## Timing
- Every output is registered. Reset values: PCOUT=0, DATA=0, ALUOP=0, LOADA=LOADB=ENABLEALU=ENABLEINSTR=0, HALTED=0. Internally: IR=0, Z=C=0, state=FETCH.
- Each instruction takes 3 cycles (FETCH, DECODE, EXECUTE). With RUN held at 1, throughput is one instruction per 3 cycles.
- INSTR must be valid by the posedge ending FETCH; PCOUT is stable throughout FETCH.
- Controls assert at the posedge entering EXECUTE and deassert at the posedge leaving it:
  - the bus's negedge ACCA load falls mid-EXECUTE;
  - its posedge ACCB load falls at the end of EXECUTE.
  - Both therefore see stable controls.
- DATA and ALUOP hold their last values outside EXECUTE. They are don't-care while controls are 0.
- A jump taken in cycle n's EXECUTE gives PCOUT=imm from the next FETCH.
- RUN deasserted during DECODE or EXECUTE does not abort the instruction. It is only sampled in FETCH.
- RST asserted in any state, mid-instruction included, immediately clears all outputs and state asynchronously. The first fetch is from address 0 in the first cycle after RST deasserts with RUN=1.

## Structure
- Shared package vsmp_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - ALUOP codes (ALU_ADD=0, SUB=1, AND=2, OR=3, XOR=4), shared with the ALU;
  - the FSM state enum.
- One sub-module: vsmp_program_counter, a DATA_W-bit register with increment, load and async reset.
- Decode and FSM logic stay in the top module.

## Test plan
- Reset then RUN=1, program {LDA 5, LDB 3, ADD, HLT}:
  - LOADA+ENABLEINSTR with DATA=5 in cycle 3;
  - LOADB+ENABLEINSTR with DATA=3 in cycle 6;
  - LOADA+ENABLEALU with ALUOP=0 in cycle 9;
  - HALTED=1 from cycle 12, PCOUT stays 4.
- PC wrap: program of 16 NOPs. PCOUT sequence is 0..15 then 0; no bus control ever asserts.
- Conditional jump: SUB with ZERO=1 driven in its EXECUTE, then JZ 9, so the next PCOUT is 9. Repeat with ZERO=0: next PCOUT is the sequential address. Check JC the same way with CARRY.
- RUN=0 in FETCH for 5 cycles: PCOUT holds, no state change. With RUN=0 asserted during EXECUTE of LDA, the load still completes.
- RST asserted mid-EXECUTE of ADD: LOADA and ENABLEALU drop asynchronously, PCOUT=0, HALTED=0, and the next fetch is at address 0.
- Illegal opcodes B-E and JMP 15: no controls assert, PC goes to 15, then wraps to 0 after the next fetch.
